// File: rtl/pulse_handshake_sync_pkg.sv
// Shared types and helpers for the DMAC clock-domain-crossing blocks.
package dmac_cdc_pkg;

   typedef enum logic {IDLE, WAIT_ACK} src_state_e;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pulse_handshake_sync_if.sv
// Event-side bundle of the pulse crossing; the source half and synch_o live in different domains.
interface pulse_handshake_sync_if #(
   parameter int DEPTH = 4
) ();
   logic                                   d_in;
   logic                                   clr_ovf_i;
   logic                                   busy_o;
   logic [dmac_cdc_pkg::cnt_w(DEPTH)-1:0]  pend_cnt_o;
   logic                                   overflow_o;
   logic                                   synch_o;

   modport master (output d_in, clr_ovf_i, input busy_o, pend_cnt_o, overflow_o, synch_o);
   modport slave  (input d_in, clr_ovf_i, output busy_o, pend_cnt_o, overflow_o, synch_o);
endinterface

// File: rtl/pulse_handshake_sync_sync.sv
// Single-bit multi-flop synchronizer; the chain is tagged so CDC/false-path constraints can find it.
module cdc_sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   (* async_reg = "true" *) logic [STAGES-1:0] cdc_sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cdc_sync_q <= '0;
      else        cdc_sync_q <= {cdc_sync_q[STAGES-2:0], d};
   end

   assign q = cdc_sync_q[STAGES-1];
endmodule

// File: rtl/pulse_handshake_sync.sv
// Lossless pulse crossing: source-side event counter feeding a 2-phase req/ack toggle handshake.
module pulse_handshake_sync
   import dmac_cdc_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     src_clk_i,
   input  logic                     src_rstn_i,
   input  logic                     des_clk_i,
   input  logic                     des_rstn_i,
   pulse_handshake_sync_if.slave    bus
);
   localparam int CW = cnt_w(DEPTH);

   src_state_e     state, state_n;
   logic           req_t, req_n;
   logic [CW-1:0]  pend_cnt, cnt_n;
   logic           overflow, ovf_n;
   logic           issue, ack_rx;
   logic           ack_s, ack_t, req_s, req_d;

   // Source domain
   always_ff @(posedge src_clk_i or negedge src_rstn_i) begin
      if (!src_rstn_i) begin
         state    <= IDLE;
         req_t    <= 1'b0;
         pend_cnt <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_n;
         req_t    <= req_n;
         pend_cnt <= cnt_n;
         overflow <= ovf_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = pend_cnt;
      issue   = 1'b0;
      ovf_n   = overflow & ~bus.clr_ovf_i;
      ack_rx  = (ack_s == req_t);
      unique case (state)
         IDLE: begin
            if (pend_cnt != '0) begin
               issue = 1'b1;
               if (!bus.d_in) cnt_n = pend_cnt - CW'(1);
            end else if (bus.d_in) begin
               issue = 1'b1;
            end
         end
         WAIT_ACK: begin
            if (ack_rx) begin
               // A concurrent event cancels the decrement, so a full queue never drops here
               if (pend_cnt != '0) begin
                  issue = 1'b1;
                  if (!bus.d_in) cnt_n = pend_cnt - CW'(1);
               end else if (bus.d_in) begin
                  issue = 1'b1;
               end else begin
                  state_n = IDLE;
               end
            end else if (bus.d_in) begin
               if (pend_cnt < CW'(DEPTH)) cnt_n = pend_cnt + CW'(1);
               else                       ovf_n = 1'b1;
            end
         end
      endcase
      if (issue) state_n = WAIT_ACK;
      req_n = req_t ^ issue;
   end

   cdc_sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk   (src_clk_i),
      .rst_n (src_rstn_i),
      .d     (ack_t),
      .q     (ack_s)
   );

   // Destination domain: the history flop doubles as the returned acknowledge
   cdc_sync_ff #(.STAGES(SYNC_STAGES)) u_req_sync (
      .clk   (des_clk_i),
      .rst_n (des_rstn_i),
      .d     (req_t),
      .q     (req_s)
   );

   always_ff @(posedge des_clk_i or negedge des_rstn_i) begin
      if (!des_rstn_i) req_d <= 1'b0;
      else             req_d <= req_s;
   end

   assign ack_t = req_d;

   assign bus.busy_o     = (state == WAIT_ACK);
   assign bus.pend_cnt_o = pend_cnt;
   assign bus.overflow_o = overflow;
   assign bus.synch_o    = req_s ^ req_d;
endmodule
